// File: rtl/handshake_watchdog.sv
// handshake_watchdog
// Watches one valid/ready handshake and counts tick rising edges while the
// request is stalled (valid high, ready low). Raises a sticky timeout after
// timeout_val ticks (0 disables the timeout) and pulses cnt_clear at stall
// start so the upstream tick counter restarts aligned to the stall.
// Tracks the tick count of the current/last stall and the largest completed stall.
//
// Build option: define WD_VALID_DROP_EN to make a valid drop during a stall
// set the sticky drop_err flag; otherwise drop_err is tied low.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | no stall in progress; waiting for valid & ~ready
// ST_WAIT    | stalled, counting ticks toward timeout_val
// ST_EXPIRED | stalled past timeout_val; still counting, waiting for exit

module handshake_watchdog #(
    parameter int CNT_BITS = 8
) (
    input  logic                clk,
    input  logic                RST,
    input  logic                tick,
    output logic                cnt_clear,
    input  logic                wd_enable,
    input  logic                req_valid,
    input  logic                req_ready,
    input  logic [CNT_BITS-1:0] timeout_val,
    input  logic                timeout_clr,
    output logic                timeout,
    output logic                timeout_pulse,
    output logic [CNT_BITS-1:0] stall_ticks,
    output logic [CNT_BITS-1:0] max_stall,
    output logic                drop_err,
    output logic [1:0]          state
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_EXPIRED = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  tick_q;
    logic [CNT_BITS-1:0]   stall_ticks_q, stall_ticks_d;
    logic [CNT_BITS-1:0]   max_stall_q, max_stall_d;
    logic                  timeout_q, timeout_d;
    logic                  timeout_pulse_q, timeout_pulse_d;

    logic                  tick_rise;
    logic                  handshake;
    logic                  stall_sat;
    logic [CNT_BITS-1:0]   stall_inc;
    logic [CNT_BITS-1:0]   stall_max;
    logic                  timeout_set;

    // Edge detect, saturating increment and running-max helpers.
    always_comb begin
        tick_rise = tick & ~tick_q;
        handshake = req_valid & req_ready;
        stall_sat = &stall_ticks_q;
        stall_inc = stall_sat ? stall_ticks_q : stall_ticks_q + 1'b1;
        stall_max = (stall_ticks_q > max_stall_q) ? stall_ticks_q : max_stall_q;
    end

    // Next-state, stall counting and timeout detection.
    // An already-saturated count never re-compares, so a timeout_val that the
    // count has already passed can never fire.
    always_comb begin
        state_d       = state_q;
        stall_ticks_d = stall_ticks_q;
        max_stall_d   = max_stall_q;
        timeout_set   = 1'b0;
        cnt_clear     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (wd_enable && req_valid && !req_ready) begin
                    state_d       = ST_WAIT;
                    cnt_clear     = 1'b1;
                    stall_ticks_d = '0;
                end
            end

            ST_WAIT: begin
                if (!wd_enable) begin
                    state_d = ST_IDLE;
                end else if (handshake || !req_valid) begin
                    state_d     = ST_IDLE;
                    max_stall_d = stall_max;
                end else if (tick_rise && !stall_sat) begin
                    stall_ticks_d = stall_inc;
                    if ((timeout_val != '0) && (stall_inc == timeout_val)) begin
                        state_d     = ST_EXPIRED;
                        timeout_set = 1'b1;
                    end
                end
            end

            ST_EXPIRED: begin
                if (!wd_enable) begin
                    state_d = ST_IDLE;
                end else if (handshake || !req_valid) begin
                    state_d     = ST_IDLE;
                    max_stall_d = stall_max;
                end else if (tick_rise) begin
                    stall_ticks_d = stall_inc;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sticky timeout: a new expiry outranks a simultaneous clear.
    always_comb begin
        timeout_pulse_d = timeout_set;
        timeout_d       = timeout_set | (timeout_q & ~timeout_clr);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (RST) begin
            state_q         <= ST_IDLE;
            tick_q          <= 1'b0;
            stall_ticks_q   <= '0;
            max_stall_q     <= '0;
            timeout_q       <= 1'b0;
            timeout_pulse_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            tick_q          <= tick;
            stall_ticks_q   <= stall_ticks_d;
            max_stall_q     <= max_stall_d;
            timeout_q       <= timeout_d;
            timeout_pulse_q <= timeout_pulse_d;
        end
    end

`ifdef WD_VALID_DROP_EN
    logic drop_err_q, drop_err_d;

    // Valid falling while stalled (and still enabled) is a protocol error.
    always_comb begin
        drop_err_d = drop_err_q | ((state_q != ST_IDLE) & wd_enable & ~req_valid);
    end

    // Sticky until reset.
    always_ff @(posedge clk) begin
        if (RST) begin
            drop_err_q <= 1'b0;
        end else begin
            drop_err_q <= drop_err_d;
        end
    end

    assign drop_err = drop_err_q;
`else
    assign drop_err = 1'b0;
`endif

    assign timeout       = timeout_q;
    assign timeout_pulse = timeout_pulse_q;
    assign stall_ticks   = stall_ticks_q;
    assign max_stall     = max_stall_q;
    assign state         = state_q;

endmodule

// File: tb/tb_handshake_watchdog.sv
// Directed self-checking bench for handshake_watchdog (CNT_BITS = 8).
module tb_handshake_watchdog;

    logic       clk = 1'b0;
    logic       RST = 1'b1;
    logic       tick = 1'b0;
    logic       cnt_clear;
    logic       wd_enable = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready = 1'b0;
    logic [7:0] timeout_val = 8'd0;
    logic       timeout_clr = 1'b0;
    logic       timeout;
    logic       timeout_pulse;
    logic [7:0] stall_ticks;
    logic [7:0] max_stall;
    logic       drop_err;
    logic [1:0] state;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef WD_VALID_DROP_EN
    localparam logic DROP_EXP = 1'b1;
`else
    localparam logic DROP_EXP = 1'b0;
`endif

    handshake_watchdog #(.CNT_BITS(8)) dut (
        .clk(clk), .RST(RST), .tick(tick), .cnt_clear(cnt_clear),
        .wd_enable(wd_enable), .req_valid(req_valid), .req_ready(req_ready),
        .timeout_val(timeout_val), .timeout_clr(timeout_clr),
        .timeout(timeout), .timeout_pulse(timeout_pulse),
        .stall_ticks(stall_ticks), .max_stall(max_stall),
        .drop_err(drop_err), .state(state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL time_limit bench did not finish in time");
        $fatal(1);
    end

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1; tick = 1'b0; wd_enable = 1'b0; req_valid = 1'b0;
        req_ready = 1'b0; timeout_val = 8'd0; timeout_clr = 1'b0;
        step();
        RST = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL rst_state got=%0d exp=0", state); end
        n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL rst_timeout got=%0d exp=0", timeout); end
        n_checks++; if (timeout_pulse !== 1'b0) begin n_fail++; $display("FAIL rst_pulse got=%0d exp=0", timeout_pulse); end
        n_checks++; if (stall_ticks !== 8'd0) begin n_fail++; $display("FAIL rst_stall got=%0d exp=0", stall_ticks); end
        n_checks++; if (max_stall !== 8'd0) begin n_fail++; $display("FAIL rst_max got=%0d exp=0", max_stall); end
        n_checks++; if (drop_err !== 1'b0) begin n_fail++; $display("FAIL rst_drop got=%0d exp=0", drop_err); end
        n_checks++; if (cnt_clear !== 1'b0) begin n_fail++; $display("FAIL rst_cnt_clear got=%0d exp=0", cnt_clear); end
    endtask

    // timeout_val=3, tick high 2 cycles out of every 5.
    task automatic test_timeout();
        do_reset();
        timeout_val = 8'd3; wd_enable = 1'b1; req_valid = 1'b1; req_ready = 1'b0;
        #1;
        n_checks++; if (cnt_clear !== 1'b1) begin n_fail++; $display("FAIL to_cnt_clear got=%0d exp=1", cnt_clear); end
        n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL to_clear_state got=%0d exp=0", state); end
        step();
        n_checks++; if (state !== 2'd1) begin n_fail++; $display("FAIL to_wait got=%0d exp=1", state); end
        n_checks++; if (cnt_clear !== 1'b0) begin n_fail++; $display("FAIL to_cnt_clear_wait got=%0d exp=0", cnt_clear); end
        for (int k = 1; k <= 3; k++) begin
            tick = 1'b1;
            step();
            n_checks++; if (stall_ticks !== 8'(k)) begin n_fail++; $display("FAIL to_ticks k=%0d got=%0d exp=%0d", k, stall_ticks, k); end
            n_checks++; if (timeout_pulse !== (k == 3)) begin n_fail++; $display("FAIL to_pulse k=%0d got=%0d exp=%0d", k, timeout_pulse, k == 3); end
            step();
            n_checks++; if (stall_ticks !== 8'(k)) begin n_fail++; $display("FAIL to_held k=%0d got=%0d exp=%0d", k, stall_ticks, k); end
            n_checks++; if (timeout_pulse !== 1'b0) begin n_fail++; $display("FAIL to_pulse_len k=%0d got=%0d exp=0", k, timeout_pulse); end
            tick = 1'b0;
            step(); step(); step();
        end
        n_checks++; if (state !== 2'd2) begin n_fail++; $display("FAIL to_expired got=%0d exp=2", state); end
        n_checks++; if (timeout !== 1'b1) begin n_fail++; $display("FAIL to_sticky got=%0d exp=1", timeout); end
        n_checks++; if (stall_ticks !== 8'd3) begin n_fail++; $display("FAIL to_final_ticks got=%0d exp=3", stall_ticks); end
        req_ready = 1'b1;
        step();
        n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL to_exit got=%0d exp=0", state); end
        n_checks++; if (max_stall !== 8'd3) begin n_fail++; $display("FAIL to_max got=%0d exp=3", max_stall); end
        n_checks++; if (timeout !== 1'b1) begin n_fail++; $display("FAIL to_hold_after_exit got=%0d exp=1", timeout); end
        req_valid = 1'b0; req_ready = 1'b0; timeout_clr = 1'b1;
        step();
        n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL to_clr got=%0d exp=0", timeout); end
        timeout_clr = 1'b0;
    endtask

    // Handshake in the same cycle as the 3rd tick rise wins.
    task automatic test_handshake_race();
        do_reset();
        timeout_val = 8'd3; wd_enable = 1'b1; req_valid = 1'b1;
        step();
        for (int k = 0; k < 2; k++) begin
            tick = 1'b1; step(); tick = 1'b0; step();
        end
        tick = 1'b1; req_ready = 1'b1;
        step();
        n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL race_state got=%0d exp=0", state); end
        n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL race_timeout got=%0d exp=0", timeout); end
        n_checks++; if (timeout_pulse !== 1'b0) begin n_fail++; $display("FAIL race_pulse got=%0d exp=0", timeout_pulse); end
        n_checks++; if (stall_ticks !== 8'd2) begin n_fail++; $display("FAIL race_ticks got=%0d exp=2", stall_ticks); end
        n_checks++; if (max_stall !== 8'd2) begin n_fail++; $display("FAIL race_max got=%0d exp=2", max_stall); end
        tick = 1'b0; req_valid = 1'b0; req_ready = 1'b0;
        step();
    endtask

    // timeout_val=0: 300 rises saturate at 255; a passed timeout_val never fires.
    task automatic test_saturate();
        do_reset();
        timeout_val = 8'd0; wd_enable = 1'b1; req_valid = 1'b1;
        step();
        for (int k = 0; k < 300; k++) begin
            tick = 1'b1; step(); tick = 1'b0; step();
        end
        n_checks++; if (stall_ticks !== 8'd255) begin n_fail++; $display("FAIL sat_ticks got=%0d exp=255", stall_ticks); end
        n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL sat_timeout got=%0d exp=0", timeout); end
        n_checks++; if (state !== 2'd1) begin n_fail++; $display("FAIL sat_state got=%0d exp=1", state); end
        timeout_val = 8'd100;
        tick = 1'b1; step(); tick = 1'b0; step();
        n_checks++; if (state !== 2'd1) begin n_fail++; $display("FAIL passed_val_state got=%0d exp=1", state); end
        n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL passed_val_timeout got=%0d exp=0", timeout); end
        req_ready = 1'b1;
        step();
        n_checks++; if (max_stall !== 8'd255) begin n_fail++; $display("FAIL sat_max got=%0d exp=255", max_stall); end
        req_valid = 1'b0; req_ready = 1'b0;
        step();
    endtask

    // Stalls of 4 then 2 ticks; max keeps 4.
    task automatic test_back_to_back();
        do_reset();
        timeout_val = 8'd0; wd_enable = 1'b1;
        req_valid = 1'b1; req_ready = 1'b0;
        step();
        for (int k = 0; k < 4; k++) begin tick = 1'b1; step(); tick = 1'b0; step(); end
        req_ready = 1'b1;
        step();
        n_checks++; if (max_stall !== 8'd4) begin n_fail++; $display("FAIL b2b_max1 got=%0d exp=4", max_stall); end
        req_ready = 1'b0;
        #1;
        n_checks++; if (cnt_clear !== 1'b1) begin n_fail++; $display("FAIL b2b_cnt_clear got=%0d exp=1", cnt_clear); end
        step();
        n_checks++; if (stall_ticks !== 8'd0) begin n_fail++; $display("FAIL b2b_restart got=%0d exp=0", stall_ticks); end
        for (int k = 0; k < 2; k++) begin tick = 1'b1; step(); tick = 1'b0; step(); end
        req_ready = 1'b1;
        step();
        n_checks++; if (stall_ticks !== 8'd2) begin n_fail++; $display("FAIL b2b_ticks2 got=%0d exp=2", stall_ticks); end
        n_checks++; if (max_stall !== 8'd4) begin n_fail++; $display("FAIL b2b_max2 got=%0d exp=4", max_stall); end
        req_valid = 1'b0; req_ready = 1'b0;
        step();
    endtask

    // Clear and set in the same cycle: set wins, clear applies afterwards.
    task automatic test_clr_vs_set();
        do_reset();
        timeout_val = 8'd1; wd_enable = 1'b1; req_valid = 1'b1; timeout_clr = 1'b1;
        step();
        tick = 1'b1;
        step();
        n_checks++; if (timeout !== 1'b1) begin n_fail++; $display("FAIL clrset_set got=%0d exp=1", timeout); end
        n_checks++; if (timeout_pulse !== 1'b1) begin n_fail++; $display("FAIL clrset_pulse got=%0d exp=1", timeout_pulse); end
        step();
        n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL clrset_clr got=%0d exp=0", timeout); end
        n_checks++; if (state !== 2'd2) begin n_fail++; $display("FAIL clrset_state got=%0d exp=2", state); end
        timeout_clr = 1'b0; tick = 1'b0;
    endtask

    // Valid dropped after one tick.
    task automatic test_valid_drop();
        do_reset();
        timeout_val = 8'd5; wd_enable = 1'b1; req_valid = 1'b1;
        step();
        tick = 1'b1; step(); tick = 1'b0; step();
        req_valid = 1'b0;
        step();
        n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL drop_state got=%0d exp=0", state); end
        n_checks++; if (max_stall !== 8'd1) begin n_fail++; $display("FAIL drop_max got=%0d exp=1", max_stall); end
        n_checks++; if (drop_err !== DROP_EXP) begin n_fail++; $display("FAIL drop_err got=%0d exp=%0d", drop_err, DROP_EXP); end
        step();
        n_checks++; if (drop_err !== DROP_EXP) begin n_fail++; $display("FAIL drop_sticky got=%0d exp=%0d", drop_err, DROP_EXP); end
    endtask

    // RST during EXPIRED, then disable mid-WAIT.
    task automatic test_reset_and_disable();
        do_reset();
        timeout_val = 8'd1; wd_enable = 1'b1; req_valid = 1'b1;
        step();
        tick = 1'b1;
        step();
        n_checks++; if (state !== 2'd2) begin n_fail++; $display("FAIL rexp_pre got=%0d exp=2", state); end
        RST = 1'b1;
        step();
        n_checks++; if ({state, timeout, timeout_pulse, stall_ticks, max_stall, drop_err} !== 21'd0)
            begin n_fail++; $display("FAIL rexp_outputs state=%0d to=%0d pulse=%0d ticks=%0d max=%0d drop=%0d exp=all0", state, timeout, timeout_pulse, stall_ticks, max_stall, drop_err); end
        RST = 1'b0; tick = 1'b0; timeout_val = 8'd0;
        step();
        n_checks++; if (state !== 2'd1) begin n_fail++; $display("FAIL dis_wait got=%0d exp=1", state); end
        for (int k = 0; k < 2; k++) begin tick = 1'b1; step(); tick = 1'b0; step(); end
        wd_enable = 1'b0;
        step();
        n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL dis_state got=%0d exp=0", state); end
        n_checks++; if (max_stall !== 8'd0) begin n_fail++; $display("FAIL dis_max got=%0d exp=0", max_stall); end
        n_checks++; if (stall_ticks !== 8'd2) begin n_fail++; $display("FAIL dis_ticks got=%0d exp=2", stall_ticks); end
        n_checks++; if (cnt_clear !== 1'b0) begin n_fail++; $display("FAIL dis_no_clear got=%0d exp=0", cnt_clear); end
        req_valid = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_timeout();
        test_handshake_race();
        test_saturate();
        test_back_to_back();
        test_clr_vs_set();
        test_valid_drop();
        test_reset_and_disable();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/handshake_watchdog.md
Name: handshake_watchdog

Overview:
Downstream consumer of the tick/rollover counter. Watches one valid/ready handshake and counts counter rollover ticks while a request is stalled (valid high, ready low). Raises a timeout after a programmable number of ticks. Pulses a clear to the counter at stall start so tick intervals are aligned to the stall.

Parameters:
CNT_BITS, 8, width of tick count, timeout_val, stall_ticks, max_stall
(none else)

Ports:
clk  in  1  clock
RST  in  1  synchronous active-high reset
tick  in  1  counter rollover flag; level signal, may stay high for several cycles
cnt_clear  out  1  one-cycle clear to counter at stall start
wd_enable  in  1  watchdog enable
req_valid  in  1  monitored request valid
req_ready  in  1  monitored request ready
timeout_val  in  CNT_BITS  ticks to timeout; 0 = never time out
timeout_clr  in  1  clears sticky timeout
timeout  out  1  sticky timeout flag
timeout_pulse  out  1  one-cycle pulse on timeout entry
stall_ticks  out  CNT_BITS  ticks in current/last stall, saturating
max_stall  out  CNT_BITS  largest completed stall_ticks since reset
drop_err  out  1  sticky valid-drop error (see Optional Feature)
state  out  2  FSM state: 0 IDLE, 1 WAIT, 2 EXPIRED

Behaviour:
- Reset (RST=1 at posedge): state=IDLE, all outputs 0, internal tick_q=0.
- Clocking: single clock. All outputs are registered except cnt_clear, which is combinational from state and inputs.
- Tick edge: tick_rise = tick & ~tick_q, where tick_q is tick registered. A held-high tick counts once.
- IDLE:
  - wd_enable & req_valid & ~req_ready -> WAIT next cycle.
  - cnt_clear=1 in this cycle.
  - stall_ticks<=0.
  - Handshake with valid&ready in the same cycle: no stall, stay IDLE.
- WAIT, priority high to low:
  1. ~wd_enable -> IDLE. max_stall is not updated.
  2. req_valid & req_ready -> IDLE. max_stall<=max(max_stall, stall_ticks). A tick_rise in the same cycle is ignored; the handshake wins and no timeout is raised.
  3. ~req_valid (valid dropped) -> IDLE. max_stall is updated as in rule 2. drop_err behaviour per Optional Feature.
  4. tick_rise -> stall_ticks<=stall_ticks+1, saturating at all-ones (no wrap).
     - If timeout_val!=0 and the incremented value == timeout_val -> EXPIRED, timeout<=1, timeout_pulse<=1 for one cycle.
- EXPIRED:
  - stall_ticks keeps saturating-counting tick_rise.
  - Exit to IDLE on handshake, valid drop or ~wd_enable. max_stall is updated on handshake or valid drop.
  - No further timeout_pulse while in EXPIRED.
- timeout_clr clears timeout on the next edge. If timeout is being set in the same cycle, set wins.
- timeout_val changed mid-WAIT: the new value applies at the next tick_rise compare only. A value already passed never fires.
- RST asserted mid-stall: immediate return to reset values on that edge; no pulse.

Optional Feature:
Macro WD_VALID_DROP_EN.
- Defined: a valid drop in WAIT/EXPIRED sets sticky drop_err (cleared only by RST).
- Undefined: drop_err tied 0; valid drop silently returns to IDLE.
- The port exists in both builds.

Test Plan:
- timeout_val=3, valid=1, ready=0, tick held high 2 cycles every 5 cycles -> cnt_clear pulse in the stall-start cycle (state still IDLE); timeout_pulse one cycle after 3rd tick rise; stall_ticks=3, state=2, timeout stays 1.
- timeout_val=3, ready asserted in same cycle as 3rd tick rise -> state IDLE, timeout=0, stall_ticks=2, max_stall=2.
- timeout_val=0, 300 tick rises with CNT_BITS=8 -> no timeout, stall_ticks saturates at 255.
- Stalls of 4 then 2 ticks, each closed by handshake -> max_stall=4; after timeout, timeout_clr=1 -> timeout=0 next cycle.
- Valid dropped in WAIT after 1 tick -> IDLE, max_stall>=1; drop_err=1 only with WD_VALID_DROP_EN.
- RST pulse during EXPIRED -> all outputs 0 next cycle; wd_enable=0 mid-WAIT -> IDLE, max_stall unchanged.
